// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding and fetch-queue entry layout.
// Entry layout: [63:32] PCNext, [31:0] instruction.
package mips_pkg;

    localparam logic [31:0] MIPS_NOP   = 32'h00000000;
    localparam int          FQ_ENTRY_W = 64;

    function automatic logic [FQ_ENTRY_W-1:0] fq_pack(
        input logic [31:0] pc_next,
        input logic [31:0] instr
    );
        return {pc_next, instr};
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Fetch-queue entry array: DEPTH x FQ_ENTRY_W, no reset.
// Ports: clk, i_we/i_waddr/i_wdata sync write; i_raddr -> o_rdata async read.
module fq_storage
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [FQ_ENTRY_W-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [FQ_ENTRY_W-1:0] o_rdata
);

    logic [FQ_ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// IF->ID decoupling queue: in-order {PCNext, instr} FIFO with flush.
// Ports: clk/nrst, i_IF_* in + o_IF_ctrl_Stall, o_ID_* out + i_ID_ctrl_Ready,
//        i_Q_ctrl_Flush, o_Q_data_Count occupancy.
module if_fetch_queue
    import mips_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_IF_ctrl_Valid,
    input  logic [31:0] i_IF_data_PCNext,
    input  logic [31:0] i_IF_data_instruction,
    output logic        o_IF_ctrl_Stall,
    input  logic        i_ID_ctrl_Ready,
    output logic        o_ID_ctrl_Valid,
    output logic [31:0] o_ID_data_PCNext,
    output logic [31:0] o_ID_data_instruction,
    input  logic        i_Q_ctrl_Flush,
    output logic [AW:0] o_Q_data_Count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [FQ_ENTRY_W-1:0] w_rdata;

    // Stall depends only on registered count, so a pop in the full
    // cycle does not open a same-cycle push slot.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = i_IF_ctrl_Valid & ~w_full & ~i_Q_ctrl_Flush;
    assign w_pop   = ~w_empty & i_ID_ctrl_Ready & ~i_Q_ctrl_Flush;

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (fq_pack(i_IF_data_PCNext, i_IF_data_instruction)),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_Q_ctrl_Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_IF_ctrl_Stall       = w_full;
    assign o_ID_ctrl_Valid       = ~w_empty;
    assign o_ID_data_PCNext      = w_empty ? MIPS_NOP : w_rdata[63:32];
    assign o_ID_data_instruction = w_empty ? MIPS_NOP : w_rdata[31:0];
    assign o_Q_data_Count        = r_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed stimulus enqueues expected
// pairs, a negedge monitor checks every ID handshake against them.
module tb_if_fetch_queue;

    logic        clk;
    logic        nrst;
    logic        i_IF_ctrl_Valid;
    logic [31:0] i_IF_data_PCNext;
    logic [31:0] i_IF_data_instruction;
    logic        o_IF_ctrl_Stall;
    logic        i_ID_ctrl_Ready;
    logic        o_ID_ctrl_Valid;
    logic [31:0] o_ID_data_PCNext;
    logic [31:0] o_ID_data_instruction;
    logic        i_Q_ctrl_Flush;
    logic [2:0]  o_Q_data_Count;

    int checks = 0;
    int passes = 0;
    logic [63:0] sbq[$];

    if_fetch_queue #(.DEPTH(4)) dut (
        .clk                   (clk),
        .nrst                  (nrst),
        .i_IF_ctrl_Valid       (i_IF_ctrl_Valid),
        .i_IF_data_PCNext      (i_IF_data_PCNext),
        .i_IF_data_instruction (i_IF_data_instruction),
        .o_IF_ctrl_Stall       (o_IF_ctrl_Stall),
        .i_ID_ctrl_Ready       (i_ID_ctrl_Ready),
        .o_ID_ctrl_Valid       (o_ID_ctrl_Valid),
        .o_ID_data_PCNext      (o_ID_data_PCNext),
        .o_ID_data_instruction (o_ID_data_instruction),
        .i_Q_ctrl_Flush        (i_Q_ctrl_Flush),
        .o_Q_data_Count        (o_Q_data_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Monitor: a transfer happens on the next edge when valid&ready&~flush.
    always @(negedge clk) begin
        if (nrst && o_ID_ctrl_Valid && i_ID_ctrl_Ready && !i_Q_ctrl_Flush) begin
            if (sbq.size() == 0) begin
                chk("unexpected_head", {o_ID_data_PCNext, o_ID_data_instruction},
                    64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("head", {o_ID_data_PCNext, o_ID_data_instruction},
                    sbq.pop_front());
            end
        end
    end

    // One cycle of stimulus; inputs applied 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic rdy,
                       input logic fl);
        i_IF_ctrl_Valid       = v;
        i_IF_data_PCNext      = pc;
        i_IF_data_instruction = ins;
        i_ID_ctrl_Ready       = rdy;
        i_Q_ctrl_Flush        = fl;
        if (v && !o_IF_ctrl_Stall && !fl) sbq.push_back({pc, ins});
        @(posedge clk);
        #1;
        if (fl) sbq.delete();
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        nrst = 1'b0;
        i_IF_ctrl_Valid = 1'b0;
        i_IF_data_PCNext = '0;
        i_IF_data_instruction = '0;
        i_ID_ctrl_Ready = 1'b0;
        i_Q_ctrl_Flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'b0, o_ID_ctrl_Valid}, 64'd0);
        chk("rst_stall", {63'b0, o_IF_ctrl_Stall}, 64'd0);
        chk("rst_count", {61'b0, o_Q_data_Count}, 64'd0);
        chk("rst_instr", {32'b0, o_ID_data_instruction}, 64'd0);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_valid", {63'b0, o_ID_ctrl_Valid}, 64'd0);
        chk("rel_pc", {32'b0, o_ID_data_PCNext}, 64'd0);

        // Single push, ready low: visible one cycle later.
        cyc(1'b1, 32'h4, 32'h20080005, 1'b0, 1'b0);
        chk("one_valid", {63'b0, o_ID_ctrl_Valid}, 64'd1);
        chk("one_pc", {32'b0, o_ID_data_PCNext}, 64'h4);
        chk("one_instr", {32'b0, o_ID_data_instruction}, 64'h20080005);
        chk("one_count", {61'b0, o_Q_data_Count}, 64'd1);
        idle(1'b1);
        chk("one_drained", {61'b0, o_Q_data_Count}, 64'd0);

        // Fill to full, then back-pressure.
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        chk("full_count", {61'b0, o_Q_data_Count}, 64'd4);
        chk("full_stall", {63'b0, o_IF_ctrl_Stall}, 64'd1);
        cyc(1'b1, 32'h14, 32'h1000_0005, 1'b0, 1'b0);
        chk("held_count", {61'b0, o_Q_data_Count}, 64'd4);
        cyc(1'b1, 32'h14, 32'h1000_0005, 1'b1, 1'b0);
        chk("fullpop_count", {61'b0, o_Q_data_Count}, 64'd3);
        chk("fullpop_stall", {63'b0, o_IF_ctrl_Stall}, 64'd0);
        cyc(1'b1, 32'h14, 32'h1000_0005, 1'b1, 1'b0);
        chk("accept14_count", {61'b0, o_Q_data_Count}, 64'd3);
        repeat (3) idle(1'b1);
        chk("fill_drained", {61'b0, o_Q_data_Count}, 64'd0);

        // Steady stream across pointer wraps.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
            chk("stream_count", {61'b0, o_Q_data_Count}, 64'd1);
        end
        idle(1'b1);
        chk("stream_drained", {61'b0, o_Q_data_Count}, 64'd0);

        // Flush with valid and ready in the same cycle.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h180 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        chk("preflush_count", {61'b0, o_Q_data_Count}, 64'd3);
        cyc(1'b1, 32'hBAD0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("flush_count", {61'b0, o_Q_data_Count}, 64'd0);
        chk("flush_valid", {63'b0, o_ID_ctrl_Valid}, 64'd0);
        chk("flush_stall", {63'b0, o_IF_ctrl_Stall}, 64'd0);
        cyc(1'b1, 32'h200, 32'h2009_0007, 1'b0, 1'b0);
        chk("postflush_pc", {32'b0, o_ID_data_PCNext}, 64'h200);
        chk("postflush_instr", {32'b0, o_ID_data_instruction}, 64'h2009_0007);
        idle(1'b1);

        // Asynchronous reset between edges.
        cyc(1'b1, 32'h280, 32'hC000_0001, 1'b0, 1'b0);
        cyc(1'b1, 32'h284, 32'hC000_0002, 1'b0, 1'b0);
        chk("prerst_count", {61'b0, o_Q_data_Count}, 64'd2);
        i_IF_ctrl_Valid = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_valid", {63'b0, o_ID_ctrl_Valid}, 64'd0);
        chk("arst_count", {61'b0, o_Q_data_Count}, 64'd0);
        chk("arst_stall", {63'b0, o_IF_ctrl_Stall}, 64'd0);
        sbq.delete();
        @(posedge clk);
        #3;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 32'h300, 32'h2010_0009, 1'b0, 1'b0);
        chk("rstpush_pc", {32'b0, o_ID_data_PCNext}, 64'h300);
        chk("rstpush_instr", {32'b0, o_ID_data_instruction}, 64'h2010_0009);
        chk("rstpush_count", {61'b0, o_Q_data_Count}, 64'd1);
        idle(1'b1);
        idle(1'b0);

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
